tos_stamp_capture: RTL

TOS_STAMP_CAPTURE -- requirements
Module: tos_stamp_capture

---
 rtl/tos_stamp_pkg.sv | 25 ++
 rtl/tos_stamp_fifo.sv | 53 +++++
 rtl/tos_stamp_capture.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/tos_stamp_pkg.sv
// Shared types for the top-of-second stamp capture block: FSM states, record
// layout and flag bit positions.
package tos_stamp_pkg;

  typedef enum logic {
    S_wait_tos,
    S_collect
  } state_e;

  // Records are carried at a fixed maximum width; the top slices them down
  // to its own SecondsWidth and delay width.
  localparam int unsigned SECONDS_W_MAX = 32;
  localparam int unsigned DELAY_W_MAX   = 32;

  localparam int unsigned FLAG_NO_STOP  = 0;
  localparam int unsigned FLAG_SAT      = 1;
  localparam int unsigned FLAG_OVERFLOW = 2;

  typedef struct packed {
    logic [SECONDS_W_MAX-1:0] seconds;
    logic [DELAY_W_MAX-1:0]   delay;
    logic [2:0]               flags;
  } stamp_rec_t;

endpackage

// File: rtl/tos_stamp_fifo.sv
// First-word-fall-through record FIFO. Depth must be a power of two; the head
// reads as all-zero while empty.
module tos_stamp_fifo #(
  parameter int unsigned Depth = 4,
  parameter type rec_t = logic [7:0],
  localparam int unsigned AW = $clog2(Depth)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  rec_t        push_rec,
  input  logic        pop,
  output logic        full,
  output logic        valid,
  output rec_t        head,
  output logic [AW:0] level
);

  rec_t          mem [Depth];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & valid;
  assign valid = (level != '0);
  assign full  = (level == (AW+1)'(Depth));
  assign head  = valid ? mem[rd_ptr] : '0;

  // NOTE: storage has no reset; the valid gating on head hides stale entries.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_rec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/tos_stamp_capture.sv
// Per-second delay-pulse capture into a record FIFO. Optional saturating
// drop counter enabled with `define TOS_STAMP_DROP_CNT_EN.
module tos_stamp_capture
  import tos_stamp_pkg::*;
#(
  parameter int unsigned SlowClocksPerSecond = 10000,
  parameter int unsigned FifoDepth           = 4,
  parameter int unsigned SecondsWidth        = 16,
  localparam int unsigned DW = $clog2(SlowClocksPerSecond),
  localparam int unsigned LW = $clog2(FifoDepth) + 1
) (
  input  logic                    clk_tf,
  input  logic                    tf_reset_l,
  input  logic                    tos_mark,
  input  logic                    stop_count_pulse,
  input  logic                    tdc_stop_next,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [SecondsWidth-1:0] rec_seconds,
  output logic [DW-1:0]           rec_delay,
  output logic [2:0]              rec_flags,
`ifdef TOS_STAMP_DROP_CNT_EN
  output logic [7:0]              drop_count,
`endif
  output logic [LW-1:0]           fifo_level
);

  logic [1:0] rst_sync;
  logic       rst_n;

  // NOTE: assertion is immediate, release is retimed through two flops.
  always_ff @(posedge clk_tf or negedge tf_reset_l) begin
    if (!tf_reset_l) rst_sync <= '0;
    else             rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  state_e                  state;
  logic [SecondsWidth-1:0] sec_cnt;
  logic [DW-1:0]           delay_acc;
  logic                    sat;
  logic                    stop_seen;
  logic                    overflow_pend;
  logic                    pulse_q;

  logic                    pulse_edge;
  logic [DW-1:0]           delay_next;
  logic                    sat_next;
  logic                    stop_next;
  logic                    push;
  logic                    pop;
  logic                    drop;
  logic                    full;
  stamp_rec_t              push_rec;
  stamp_rec_t              head;

  // NOTE: every always_comb output is defaulted first so no latch is inferred.
  always_comb begin
    pulse_edge = stop_count_pulse & ~pulse_q;
    delay_next = delay_acc;
    sat_next   = sat;
    if (pulse_edge) begin
      if (delay_acc == '1) sat_next   = 1'b1;
      else                 delay_next = delay_acc + DW'(1);
    end
    stop_next = stop_seen | tdc_stop_next;
    push      = (state == S_collect) & tos_mark;
    pop       = rec_valid & rec_ready;
    drop      = push & full & ~pop;

    // The closing record includes whatever arrives in the tos_mark cycle.
    push_rec                       = '0;
    push_rec.seconds               = SECONDS_W_MAX'(sec_cnt);
    push_rec.delay                 = DELAY_W_MAX'(delay_next);
    push_rec.flags[FLAG_OVERFLOW]  = overflow_pend;
    push_rec.flags[FLAG_SAT]       = sat_next;
    push_rec.flags[FLAG_NO_STOP]   = ~stop_next;
  end

  always_ff @(posedge clk_tf or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_wait_tos;
      sec_cnt       <= '0;
      delay_acc     <= '0;
      sat           <= 1'b0;
      stop_seen     <= 1'b0;
      overflow_pend <= 1'b0;
      pulse_q       <= 1'b0;
    end else begin
      pulse_q <= stop_count_pulse;
      if (drop)      overflow_pend <= 1'b1;
      else if (push) overflow_pend <= 1'b0;
      unique case (state)
        S_wait_tos: begin
          if (tos_mark) state <= S_collect;
        end
        S_collect: begin
          if (tos_mark) begin
            sec_cnt   <= sec_cnt + SecondsWidth'(1);
            delay_acc <= '0;
            sat       <= 1'b0;
            stop_seen <= 1'b0;
          end else begin
            delay_acc <= delay_next;
            sat       <= sat_next;
            stop_seen <= stop_next;
          end
        end
        default: state <= S_wait_tos;
      endcase
    end
  end

`ifdef TOS_STAMP_DROP_CNT_EN
  always_ff @(posedge clk_tf or negedge rst_n) begin
    if (!rst_n)                       drop_count <= '0;
    else if (drop && drop_count != '1) drop_count <= drop_count + 8'd1;
  end
`endif

  tos_stamp_fifo #(
    .Depth (FifoDepth),
    .rec_t (stamp_rec_t)
  ) u_fifo (
    .clk      (clk_tf),
    .rst_n    (rst_n),
    .push     (push),
    .push_rec (push_rec),
    .pop      (pop),
    .full     (full),
    .valid    (rec_valid),
    .head     (head),
    .level    (fifo_level)
  );

  // Upper bits of the wide record fields are always zero here.
  logic [SECONDS_W_MAX+DELAY_W_MAX-1:0] unused_rec_bits;
  assign unused_rec_bits = {head.seconds, head.delay};

  assign rec_seconds = head.seconds[SecondsWidth-1:0];
  assign rec_delay   = head.delay[DW-1:0];
  assign rec_flags   = head.flags;

endmodule
